byte_lane_sched: RTL and testbench

Round-robin scheduler that shares a three-lane byte word between up to three byte producers. Each cycle it grants one producer, which delivers one byte. It packs accepted bytes in grant order into a packed `[0:2][7:0]` word and presents that word downstream with a valid/ready handshake. It sits in front of the lane-array consumer (the `sig_g`/`sig_k`-style packed-array ports) and converts per-requester unpacked byte inputs into that packed form.

---
 rtl/byte_lane_sched_pkg.sv | 24 ++
 rtl/byte_lane_sched_rr_arb3.sv | 36 +++
 rtl/byte_lane_sched.sv | 114 +++++++++++
 tb/tb_byte_lane_sched.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_lane_sched_pkg.sv
// Shared types and constants for the byte-lane scheduler.
// Used by byte_lane_sched and rr_arb3.
package byte_lane_pkg;

    localparam int NUM_LANES = 3;
    localparam int LANE_W    = 8;
    localparam int SRC_W     = 2;

    typedef logic [LANE_W-1:0]                 lane_t;
    typedef logic [0:NUM_LANES-1][LANE_W-1:0]  word_t;
    typedef logic [SRC_W-1:0]                  src_t;
    typedef logic [0:NUM_LANES-1][SRC_W-1:0]   src_word_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } sched_state_e;

    // Search start for the next grant: the requester after the one just served.
    function automatic src_t next_ptr(input src_t granted);
        return (granted == src_t'(NUM_LANES - 1)) ? src_t'(0) : src_t'(granted + src_t'(1));
    endfunction

endpackage

// File: rtl/byte_lane_sched_rr_arb3.sv
// Combinational three-way round-robin arbiter.
// The search starts at ptr and wraps; a pointer of 3 is treated as 0.
module rr_arb3
    import byte_lane_pkg::*;
(
    input  logic [2:0] req,
    input  src_t       ptr,
    output logic [2:0] gnt,
    output src_t       idx,
    output logic       any
);

    src_t       start;
    logic [2:0] cand;

    assign start = (ptr == 2'd3) ? 2'd0 : ptr;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < 3; i++) begin
            cand = {1'b0, start} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!any && req[cand[1:0]]) begin
                any            = 1'b1;
                gnt[cand[1:0]] = 1'b1;
                idx            = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/byte_lane_sched.sv
// Round-robin byte packer: grants one requester per cycle, packs bytes into a 3-lane word.
// Define BYTE_LANE_SCHED_FLUSH_EN to add the flush port for emitting partial words.
module byte_lane_sched #(
    parameter int NUM_LANES = byte_lane_pkg::NUM_LANES,
    parameter int LANE_W    = byte_lane_pkg::LANE_W
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef BYTE_LANE_SCHED_FLUSH_EN
    input  logic                                flush,
`endif
    input  logic [NUM_LANES-1:0]                req_valid,
    input  logic [LANE_W-1:0]                   req_data [NUM_LANES],
    output logic [NUM_LANES-1:0]                req_ready,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [0:NUM_LANES-1][LANE_W-1:0]    out_data,
    output logic [0:NUM_LANES-1][1:0]           out_src,
    output logic [1:0]                          out_fill
);

    import byte_lane_pkg::*;

    sched_state_e state_q, state_d;
    logic [1:0]   fill_cnt_q, fill_cnt_d;
    word_t        lanes_q, lanes_d;
    src_word_t    src_q, src_d;
    src_t         prio_q, prio_d;

    logic [2:0]   arb_gnt;
    src_t         arb_idx;
    logic         arb_any;
    lane_t        sel_byte;
    logic         flush_w;

`ifdef BYTE_LANE_SCHED_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    rr_arb3 u_arb (
        .req (req_valid),
        .ptr (prio_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_byte = req_data[arb_idx];

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        lanes_d    = lanes_q;
        src_d      = src_q;
        prio_d     = prio_q;
        req_ready  = '0;
        case (state_q)
            FILL: begin
                req_ready = arb_gnt;
                if (arb_any) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (fill_cnt_q == 2'(i)) begin
                            lanes_d[i] = sel_byte;
                            src_d[i]   = arb_idx;
                        end
                    end
                    fill_cnt_d = fill_cnt_q + 2'd1;
                    prio_d     = next_ptr(arb_idx);
                end
                // A flush counts the byte accepted in the same cycle.
                if (fill_cnt_d == 2'd3) begin
                    state_d = HOLD;
                end else if (flush_w && (fill_cnt_d != 2'd0)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                    lanes_d    = '0;
                    src_d      = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            lanes_q    <= '0;
            src_q      <= '0;
            prio_q     <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            lanes_q    <= lanes_d;
            src_q      <= src_d;
            prio_q     <= prio_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = lanes_q;
    assign out_src   = src_q;
    assign out_fill  = fill_cnt_q;

endmodule

// File: tb/tb_byte_lane_sched.sv
// Directed bench for byte_lane_sched with hand-computed expectations.
// Flush scenarios are included when BYTE_LANE_SCHED_FLUSH_EN is defined.
module tb_byte_lane_sched;

    logic                clk;
    logic                rst;
    logic                flush;
    logic [2:0]          req_valid;
    logic [7:0]          req_data [3];
    logic [2:0]          req_ready;
    logic                out_valid;
    logic                out_ready;
    logic [0:2][7:0]     out_data;
    logic [0:2][1:0]     out_src;
    logic [1:0]          out_fill;

    int total = 0;
    int bad   = 0;

    byte_lane_sched dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BYTE_LANE_SCHED_FLUSH_EN
        .flush     (flush),
`endif
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_fill  (out_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 3'b000;
        req_data  = '{8'h00, 8'h00, 8'h00};
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  {8'b0, out_data}, 32'h0);
        chk("rst_out_src",   {26'b0, out_src}, 32'h0);
        chk("rst_out_fill",  {30'b0, out_fill}, 32'd0);
        chk("rst_req_ready", {29'b0, req_ready}, 32'd0);
        rst = 1'b0;

        // Three-way contention from reset: grants 0, 1, 2.
        req_valid = 3'b111;
        req_data  = '{8'hA0, 8'hB1, 8'hC2};
        #1;
        chk("rr_gnt0", {29'b0, req_ready}, 32'b001);
        tick();
        chk("rr_gnt1", {29'b0, req_ready}, 32'b010);
        chk("rr_not_valid_yet", {31'b0, out_valid}, 32'd0);
        tick();
        chk("rr_gnt2", {29'b0, req_ready}, 32'b100);
        tick();
        chk("rr_out_valid", {31'b0, out_valid}, 32'd1);
        chk("rr_out_data",  {8'b0, out_data}, 32'hA0B1C2);
        chk("rr_out_src",   {26'b0, out_src}, 32'h06);
        chk("rr_out_fill",  {30'b0, out_fill}, 32'd3);
        chk("rr_hold_ready", {29'b0, req_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("hs_no_grant", {29'b0, req_ready}, 32'd0);
        tick();
        out_ready = 1'b0;
        chk("hs_valid_drop", {31'b0, out_valid}, 32'd0);
        chk("hs_data_clear", {8'b0, out_data}, 32'h0);

        // Only requester 2 active.
        req_valid   = 3'b100;
        req_data[2] = 8'h11;
        #1;
        chk("r2_gnt", {29'b0, req_ready}, 32'b100);
        tick();
        req_data[2] = 8'h22;
        tick();
        req_data[2] = 8'h33;
        tick();
        chk("r2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("r2_out_data",  {8'b0, out_data}, 32'h112233);
        chk("r2_out_src",   {26'b0, out_src}, 32'h2A);
        chk("r2_out_fill",  {30'b0, out_fill}, 32'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Requesters 0 and 1: grants 0, 1, 0 so the last grant is requester 0.
        req_valid   = 3'b011;
        req_data[0] = 8'h10;
        req_data[1] = 8'h20;
        #1;
        chk("mix_gnt0", {29'b0, req_ready}, 32'b001);
        tick();
        chk("mix_gnt1", {29'b0, req_ready}, 32'b010);
        tick();
        req_data[0] = 8'h30;
        #1;
        chk("mix_gnt2", {29'b0, req_ready}, 32'b001);
        tick();

        // Backpressure for 5 cycles with all requesters pending.
        req_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", {29'b0, req_ready}, 32'd0);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_data",  {8'b0, out_data}, 32'h102030);
            tick();
        end
        chk("bp_src",  {26'b0, out_src}, 32'h04);
        chk("bp_fill", {30'b0, out_fill}, 32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_hs_ready", {29'b0, req_ready}, 32'd0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_next_gnt", {29'b0, req_ready}, 32'b010);

        // Two bytes accepted, then reset discards them.
        tick();
        chk("rs_gnt2", {29'b0, req_ready}, 32'b100);
        tick();
        chk("rs_fill2", {30'b0, out_fill}, 32'd2);
        rst       = 1'b1;
        req_valid = 3'b000;
        tick();
        rst = 1'b0;
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_fill",  {30'b0, out_fill}, 32'd0);
        chk("rs_data",  {8'b0, out_data}, 32'h0);
        tick();
        chk("rs_valid_after", {31'b0, out_valid}, 32'd0);
        req_valid = 3'b111;
        req_data  = '{8'hA0, 8'hB1, 8'hC2};
        #1;
        chk("rs_tie_req0", {29'b0, req_ready}, 32'b001);
        tick();
        tick();
        tick();
        chk("rs_word_valid", {31'b0, out_valid}, 32'd1);
        chk("rs_word_data",  {8'b0, out_data}, 32'hA0B1C2);
        chk("rs_word_src",   {26'b0, out_src}, 32'h06);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 3'b000;

`ifdef BYTE_LANE_SCHED_FLUSH_EN
        // Pointer is 0 here; a lone request from requester 1 is still granted.
        req_valid   = 3'b010;
        req_data[1] = 8'h5A;
        #1;
        chk("fl_gnt", {29'b0, req_ready}, 32'b010);
        tick();
        req_valid = 3'b000;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd1);
        chk("fl_fill",  {30'b0, out_fill}, 32'd1);
        chk("fl_data",  {8'b0, out_data}, 32'h5A0000);
        chk("fl_src",   {26'b0, out_src}, 32'h10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        chk("fl_empty", {31'b0, out_valid}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
